// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter control path: debounce FSM state
// encoding and the default debounce depth used by the board-top wrapper.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM_P = 2'd1,
    ST_HELD  = 2'd2,
    ST_ARM_R = 2'd3
  } btn_state_t;

  localparam int unsigned DEBOUNCE_DEFAULT = 16;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM with sample counter,
// and registered level / press / release / busy outputs.
module btn_debounce_ch
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic clear,
  input  logic p,
  output logic level,
  output logic press,
  output logic rel,
  output logic busy
);

  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          s1, s2;
  btn_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          press_nxt, rel_nxt, level_nxt, busy_nxt;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= p;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= ST_IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      press <= press_nxt;
      rel   <= rel_nxt;
      busy  <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s2) begin
          state_nxt = ST_ARM_P;
          cnt_nxt   = CW'(1);
        end
      end
      ST_ARM_P: begin
        if (!s2) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_HELD: begin
        if (!s2) begin
          state_nxt = ST_ARM_R;
          cnt_nxt   = CW'(1);
        end
      end
      ST_ARM_R: begin
        if (s2) begin
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          rel_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // Level and busy are decoded from the next state so they register on the
    // same edge as the transition that changes them.
    level_nxt = (state_nxt == ST_HELD) || (state_nxt == ST_ARM_R);
    busy_nxt  = (state_nxt == ST_ARM_P) || (state_nxt == ST_ARM_R);
  end

endmodule

// File: rtl/btn_debounce_ctrl.sv
// Debounces N_BTN raw push-buttons into clean level and press/release pulses
// for the loadable counter's control inputs.
module btn_debounce_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned N_BTN      = 4,
  parameter int unsigned DEBOUNCE   = DEBOUNCE_DEFAULT,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_busy
);

  logic [N_BTN-1:0] p;

  assign p = btn_raw ^ {N_BTN{ACTIVE_LOW}};

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE(DEBOUNCE)
    ) u_ch (
      .clk  (clk),
      .clear(clear),
      .p    (p[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i]),
      .busy (btn_busy[i])
    );
  end

endmodule
